// File: rtl/instr_cycle_ctrl_pkg.sv
// Shared definitions for the 19-bit CPU instruction-cycle sequencer.
// The INTR state exists only when SEQ_INTR_EN is defined.
package cpu19_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
`ifdef SEQ_INTR_EN
        ST_EXEC   = 3'd3,
        ST_INTR   = 3'd4
`else
        ST_EXEC   = 3'd3
`endif
    } seq_state_e;

    localparam logic [1:0] PH_FETCH  = 2'b00;
    localparam logic [1:0] PH_DECODE = 2'b01;
    localparam logic [1:0] PH_EXEC   = 2'b10;
    localparam logic [1:0] PH_INTR   = 2'b11;

    localparam logic [3:0] FETCH_LAST = 4'd1;
    localparam logic [3:0] DECODE_T   = 4'd2;
    localparam logic [3:0] EXEC_FIRST = 4'd3;
    localparam logic [3:0] INTR_LAST  = 4'd2;
    localparam logic [3:0] T_LAST     = 4'd15;

    // IDLE reports the fetch code so the phase bus idles at zero.
    function automatic logic [1:0] phase_of(seq_state_e st);
        logic [1:0] ph;
        ph = PH_FETCH;
        case (st)
            ST_DECODE: ph = PH_DECODE;
            ST_EXEC:   ph = PH_EXEC;
`ifdef SEQ_INTR_EN
            ST_INTR:   ph = PH_INTR;
`endif
            default:   ph = PH_FETCH;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/instr_cycle_ctrl_if.sv
// Control-unit / memory / interrupt handshake bundle of the instruction-cycle sequencer.
// master drives the requests; slave is the sequencer itself.
interface instr_cycle_ctrl_if;

    logic        start;
    logic        mem_busy;
    logic        sc_clr;
    logic        halt;
    logic        irq;
    logic        ien;
    logic [15:0] T;
    logic [1:0]  phase;
    logic        running;
    logic        instr_done;
    logic        int_ack;
    logic        seq_err;

    modport master (
        output start, mem_busy, sc_clr, halt, irq, ien,
        input  T, phase, running, instr_done, int_ack, seq_err
    );

    modport slave (
        input  start, mem_busy, sc_clr, halt, irq, ien,
        output T, phase, running, instr_done, int_ack, seq_err
    );

endinterface

// File: rtl/instr_cycle_ctrl_t_decoder.sv
// 4-to-16 one-hot timing decoder fed by the registered sequence counter.
// en low forces every timing line to zero.
module seq_t_decoder (
    input  logic [3:0]  cnt,
    input  logic        en,
    output logic [15:0] t
);

    always_comb begin
        t = '0;
        if (en) begin
            t[cnt] = 1'b1;
        end
    end

endmodule

// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle controller: sequences FETCH/DECODE/EXEC(/INTR) and the T0-T15 timing counter.
// Define SEQ_INTR_EN to build the interrupt cycle (INTR state, irq/ien sampling, int_ack).
module instr_cycle_ctrl
    import cpu19_seq_pkg::*;
(
    input  logic                CLK,
    input  logic                CLR_N,
    instr_cycle_ctrl_if.slave   bus
);

    seq_state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       done_q, done_nxt;
    logic       ack_q, ack_nxt;
    logic       err_q, err_set;
    logic       eoi;

`ifndef SEQ_INTR_EN
    logic unused_intr;
    assign unused_intr = bus.irq ^ bus.ien;
`endif

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
            ack_q  <= ack_nxt;
            err_q  <= err_q | err_set;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        err_set   = 1'b0;
        eoi       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_FETCH;
                    cnt_nxt   = '0;
                end
            end

            ST_FETCH: begin
                if (!bus.mem_busy) begin
                    if (cnt == FETCH_LAST) begin
                        state_nxt = ST_DECODE;
                        cnt_nxt   = DECODE_T;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end

            ST_DECODE: begin
                state_nxt = ST_EXEC;
                cnt_nxt   = EXEC_FIRST;
            end

            ST_EXEC: begin
                if (!bus.mem_busy) begin
                    if (bus.sc_clr) begin
                        eoi = 1'b1;
                    end else if (cnt == T_LAST) begin
                        // Overrun ends the instruction as if sc_clr arrived with halt low.
                        eoi     = 1'b1;
                        err_set = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                if (eoi) begin
                    cnt_nxt  = '0;
                    done_nxt = 1'b1;
                    if (bus.sc_clr && bus.halt) begin
                        state_nxt = ST_IDLE;
`ifdef SEQ_INTR_EN
                    end else if (bus.irq && bus.ien) begin
                        state_nxt = ST_INTR;
                        ack_nxt   = 1'b1;
`endif
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end

`ifdef SEQ_INTR_EN
            ST_INTR: begin
                if (!bus.mem_busy) begin
                    if (cnt == INTR_LAST) begin
                        state_nxt = ST_FETCH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
`endif

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    seq_t_decoder u_t_decoder (
        .cnt (cnt),
        .en  (state != ST_IDLE),
        .t   (bus.T)
    );

    assign bus.phase      = phase_of(state);
    assign bus.running    = (state != ST_IDLE);
    assign bus.instr_done = done_q;
    assign bus.int_ack    = ack_q;
    assign bus.seq_err    = err_q;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Scoreboard bench for instr_cycle_ctrl: each step drives inputs, pushes the expected outputs, then compares after the edge.
module tb_instr_cycle_ctrl;
    import cpu19_seq_pkg::*;

    logic CLK = 1'b0;
    logic CLR_N = 1'b0;
    int   checks = 0;
    int   failures = 0;

    localparam int DN = 1;
    localparam int AK = 2;
    localparam int ER = 4;

    typedef struct packed {
        logic        rstn;
        logic [5:0]  in;
        logic [21:0] exp;
    } step_t;

    step_t        plan[$];
    logic [21:0]  sb[$];

    instr_cycle_ctrl_if bus();

    instr_cycle_ctrl dut (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // in = {start, mem_busy, sc_clr, halt, irq, ien}
    function automatic logic [5:0] I(bit st, bit bz, bit sc, bit hl, bit rq, bit en);
        return {st, bz, sc, hl, rq, en};
    endfunction

    // expected = {T, phase, running, instr_done, int_ack, seq_err}; t < 0 means IDLE
    function automatic logic [21:0] ex(int t, logic [1:0] ph, int fl);
        logic [15:0] tv;
        logic [3:0]  ti;
        tv = '0;
        ti = t[3:0];
        if (t >= 0) tv[ti] = 1'b1;
        return {tv, ph, (t >= 0) ? 1'b1 : 1'b0, fl[0], fl[1], fl[2]};
    endfunction

    task automatic add(input logic [5:0] in, input logic [21:0] e);
        plan.push_back('{rstn: 1'b1, in: in, exp: e});
    endtask

    task automatic add_rst(input logic [5:0] in, input logic [21:0] e);
        plan.push_back('{rstn: 1'b0, in: in, exp: e});
    endtask

    task automatic drive(input logic rstn, input logic [5:0] v);
        CLR_N = rstn;
        {bus.start, bus.mem_busy, bus.sc_clr, bus.halt, bus.irq, bus.ien} = v;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [21:0] observed();
        return {bus.T, bus.phase, bus.running, bus.instr_done, bus.int_ack, bus.seq_err};
    endfunction

    task automatic test_reset();
        step_t s;
        logic [21:0] e, o;
        int i;
        add_rst(I(1,1,1,0,1,1), ex(-1, PH_FETCH, 0));
        add_rst(I(1,0,0,0,0,0), ex(-1, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(-1, PH_FETCH, 0));
        i = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            sb.push_back(s.exp);
            drive(s.rstn, s.in);
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset step %0d: got %h want %h", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_basic();
        step_t s;
        logic [21:0] e, o;
        int i;
        add(I(1,0,0,0,0,0), ex(0, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(1, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(2, PH_DECODE, 0));
        add(I(0,0,0,0,0,0), ex(3, PH_EXEC, 0));
        add(I(0,0,0,0,0,0), ex(4, PH_EXEC, 0));
        add(I(0,0,1,0,0,0), ex(0, PH_FETCH, DN));
        add(I(0,0,0,0,0,0), ex(1, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(2, PH_DECODE, 0));
        add(I(0,0,0,0,0,0), ex(3, PH_EXEC, 0));
        add(I(0,0,1,1,0,0), ex(-1, PH_FETCH, DN));
        add(I(0,0,0,0,0,0), ex(-1, PH_FETCH, 0));
        add(I(1,0,0,0,0,0), ex(0, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(1, PH_FETCH, 0));
        add(I(1,0,0,0,0,0), ex(2, PH_DECODE, 0));
        add(I(0,0,0,0,0,0), ex(3, PH_EXEC, 0));
        add(I(0,0,1,1,0,0), ex(-1, PH_FETCH, DN));
        add(I(0,0,0,0,0,0), ex(-1, PH_FETCH, 0));
        i = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            sb.push_back(s.exp);
            drive(s.rstn, s.in);
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL basic step %0d: got %h want %h", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_mem_busy();
        step_t s;
        logic [21:0] e, o;
        int i;
        add(I(1,1,0,0,0,0), ex(0, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(1, PH_FETCH, 0));
        add(I(0,1,0,0,0,0), ex(1, PH_FETCH, 0));
        add(I(0,1,0,0,0,0), ex(1, PH_FETCH, 0));
        add(I(0,1,0,0,0,0), ex(1, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(2, PH_DECODE, 0));
        add(I(0,1,0,0,0,0), ex(3, PH_EXEC, 0));
        add(I(0,1,1,1,0,0), ex(3, PH_EXEC, 0));
        add(I(0,0,0,0,0,0), ex(4, PH_EXEC, 0));
        add(I(0,1,0,0,0,0), ex(4, PH_EXEC, 0));
        add(I(0,0,1,1,0,0), ex(-1, PH_FETCH, DN));
        add(I(0,1,0,0,0,0), ex(-1, PH_FETCH, 0));
        i = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            sb.push_back(s.exp);
            drive(s.rstn, s.in);
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mem_busy step %0d: got %h want %h", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_interrupt();
        step_t s;
        logic [21:0] e, o;
        int i;
        // ien=0: interrupt request must be ignored
        add(I(1,0,0,0,1,0), ex(0, PH_FETCH, 0));
        add(I(0,0,0,0,1,0), ex(1, PH_FETCH, 0));
        add(I(0,0,0,0,1,0), ex(2, PH_DECODE, 0));
        add(I(0,0,0,0,1,0), ex(3, PH_EXEC, 0));
        add(I(0,0,1,0,1,0), ex(0, PH_FETCH, DN));
        add(I(0,0,0,0,1,1), ex(1, PH_FETCH, 0));
        add(I(0,0,0,0,1,1), ex(2, PH_DECODE, 0));
        for (int k = 3; k <= 5; k++) add(I(0,0,0,0,1,1), ex(k, PH_EXEC, 0));
`ifdef SEQ_INTR_EN
        add(I(0,0,1,0,1,1), ex(0, PH_INTR, DN | AK));
        add(I(0,0,0,0,1,1), ex(1, PH_INTR, 0));
        add(I(0,0,0,0,1,1), ex(2, PH_INTR, 0));
        add(I(0,0,0,0,1,1), ex(0, PH_FETCH, 0));
`else
        add(I(0,0,1,0,1,1), ex(0, PH_FETCH, DN));
`endif
        add(I(0,0,0,0,1,1), ex(1, PH_FETCH, 0));
        add(I(0,0,0,0,1,1), ex(2, PH_DECODE, 0));
        add(I(0,0,0,0,1,1), ex(3, PH_EXEC, 0));
        add(I(0,0,1,1,1,1), ex(-1, PH_FETCH, DN));
        add(I(0,0,0,0,0,0), ex(-1, PH_FETCH, 0));
        i = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            sb.push_back(s.exp);
            drive(s.rstn, s.in);
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL interrupt step %0d: got %h want %h", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_overrun();
        step_t s;
        logic [21:0] e, o;
        int i;
        add(I(1,0,0,0,0,0), ex(0, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(1, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(2, PH_DECODE, 0));
        for (int k = 3; k <= 15; k++) add(I(0,0,0,0,0,0), ex(k, PH_EXEC, 0));
        add(I(0,0,0,1,0,0), ex(0, PH_FETCH, DN | ER));
        add(I(0,0,0,0,0,0), ex(1, PH_FETCH, ER));
        add(I(0,0,0,0,0,0), ex(2, PH_DECODE, ER));
        add(I(0,0,0,0,0,0), ex(3, PH_EXEC, ER));
        add(I(0,0,1,1,0,0), ex(-1, PH_FETCH, DN | ER));
        add(I(0,0,0,0,0,0), ex(-1, PH_FETCH, ER));
        i = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            sb.push_back(s.exp);
            drive(s.rstn, s.in);
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL overrun step %0d: got %h want %h", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_reset_mid();
        step_t s;
        logic [21:0] e, o;
        int i;
        add(I(1,0,0,0,0,0), ex(0, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(1, PH_FETCH, 0));
        add(I(0,0,0,0,0,0), ex(2, PH_DECODE, 0));
        for (int k = 3; k <= 6; k++) add(I(0,0,0,0,0,0), ex(k, PH_EXEC, 0));
        add_rst(I(0,1,1,0,0,0), ex(-1, PH_FETCH, 0));
        add(I(0,0,1,0,0,0), ex(-1, PH_FETCH, 0));
        add(I(1,0,0,0,0,0), ex(0, PH_FETCH, 0));
        i = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            sb.push_back(s.exp);
            drive(s.rstn, s.in);
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid step %0d: got %h want %h", i, o, e);
            end
            i++;
        end
    endtask

    initial begin
        {bus.start, bus.mem_busy, bus.sc_clr, bus.halt, bus.irq, bus.ien} = '0;
        test_reset();
        test_basic();
        test_mem_busy();
        test_interrupt();
        test_overrun();
        test_reset();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
